// File: rtl/embed_seq_apb4_mst.sv
// embed_seq_apb4_mst: APB4 master fed by an embedded sequencer core.
//
// Requests arrive on a valid/ready channel and are queued in a small command
// FIFO. Each entry is run as one APB4 transfer (SETUP then ACCESS), with byte
// strobes, slave error capture and an optional ACCESS timeout. Results come
// back on a valid/ready response channel, strictly in acceptance order.
//
// Ports
//   clk_i, rst_i        clock, synchronous active-high reset
//   req_*               request channel (valid/ready, write, addr, wdata, strb)
//   rsp_*               response channel (valid/ready, rdata, err: 00 ok,
//                       01 slave error, 10 timeout)
//   p*                  APB4 master interface
//   busy_o              queued work, transfer in flight or response pending
`timescale 1ns / 1ps

module embed_seq_apb4_mst #(
  parameter int unsigned P_ADDR_WIDTH = 32,
  parameter int unsigned P_DATA_WIDTH = 32,
  parameter int unsigned P_FIFO_DEPTH = 2,
  parameter int unsigned P_TIMEOUT    = 256
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_write_i,
  input  logic [P_ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [P_DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [P_DATA_WIDTH/8-1:0] req_strb_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [P_DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic [1:0]                rsp_err_o,
  output logic [P_ADDR_WIDTH-1:0]   paddr_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [P_DATA_WIDTH-1:0]   pwdata_o,
  output logic [P_DATA_WIDTH/8-1:0] pstrb_o,
  input  logic                      pready_i,
  input  logic [P_DATA_WIDTH-1:0]   prdata_i,
  input  logic                      pslverr_i,
  output logic                      busy_o
);

  localparam int unsigned StrbW    = P_DATA_WIDTH / 8;
  localparam int unsigned EntryW   = 1 + P_ADDR_WIDTH + P_DATA_WIDTH + StrbW;
  localparam int unsigned PtrW     = (P_FIFO_DEPTH > 1) ? $clog2(P_FIFO_DEPTH) : 1;
  localparam int unsigned MemDepth = 1 << PtrW;
  localparam int unsigned CntW     = $clog2(P_FIFO_DEPTH + 1);
  localparam logic [15:0] TimeoutLast = (P_TIMEOUT == 0) ? 16'd0 : 16'(P_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                 state_q, state_d;
  logic [EntryW-1:0]      mem_q [MemDepth];
  logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]        count_q, count_d;
  logic                   ready_q, ready_d;
  logic [P_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                   pwrite_q, pwrite_d;
  logic [P_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [StrbW-1:0]       pstrb_q, pstrb_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [P_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]             rsp_err_q, rsp_err_d;
  logic [15:0]            tcnt_q, tcnt_d;

  logic                    push, pop, fifo_empty, timeout_hit;
  logic                    head_write;
  logic [P_ADDR_WIDTH-1:0] head_addr;
  logic [P_DATA_WIDTH-1:0] head_wdata;
  logic [StrbW-1:0]        head_strb;

  assign push        = req_valid_i && ready_q;
  assign fifo_empty  = (count_q == '0);
  assign timeout_hit = (P_TIMEOUT != 0) && (tcnt_q == TimeoutLast);
  assign {head_write, head_addr, head_wdata, head_strb} = mem_q[rd_ptr_q];

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready_i;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tcnt_d      = tcnt_q;

    unique case (state_q)
      StIdle: begin
        // Only start when the response slot is free (or freeing now), so a
        // pending response can never be overwritten.
        if (!fifo_empty && (!rsp_valid_q || rsp_ready_i)) begin
          pop      = 1'b1;
          state_d  = StSetup;
          paddr_d  = head_addr;
          pwrite_d = head_write;
          pwdata_d = head_wdata;
          pstrb_d  = head_write ? head_strb : '0;
        end
      end
      StSetup: begin
        tcnt_d  = '0;
        state_d = StAccess;
      end
      StAccess: begin
        if (pready_i) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = (!pwrite_q && !pslverr_i) ? prdata_i : '0;
          rsp_err_d   = pslverr_i ? 2'b01 : 2'b00;
          state_d     = StIdle;
        end else if (timeout_hit) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 2'b10;
          state_d     = StIdle;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PtrW'(P_FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(P_FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    count_d = count_q + CntW'(push) - CntW'(pop);
    ready_d = (count_d != CntW'(P_FIFO_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 2'b00;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tcnt_q      <= tcnt_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {req_write_i, req_addr_i, req_wdata_i, req_strb_i};
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign paddr_o     = paddr_q;
  assign psel_o      = (state_q != StIdle);
  assign penable_o   = (state_q == StAccess);
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign busy_o      = !fifo_empty || (state_q != StIdle) || rsp_valid_q;

endmodule

// File: tb/tb_embed_seq_apb4_mst.sv
// Directed bench for embed_seq_apb4_mst (32-bit, 2-entry FIFO, timeout 8).
`timescale 1ns / 1ps

module tb_embed_seq_apb4_mst;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_strb_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_err_o;
  logic [31:0] paddr_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic        pready_i;
  logic [31:0] prdata_i;
  logic        pslverr_i;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  embed_seq_apb4_mst #(
    .P_ADDR_WIDTH(32),
    .P_DATA_WIDTH(32),
    .P_FIFO_DEPTH(2),
    .P_TIMEOUT   (8)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i (req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_strb_i (req_strb_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o  (rsp_err_o),
    .paddr_o    (paddr_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .pwrite_o   (pwrite_o),
    .pwdata_o   (pwdata_o),
    .pstrb_o    (pstrb_o),
    .pready_i   (pready_i),
    .prdata_i   (prdata_i),
    .pslverr_i  (pslverr_i),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Sample and drive 1ns after each rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic ok);
    n_tests++;
    if (ok !== 1'b1) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic set_req(input logic v, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid_i = v;
    req_write_i = w;
    req_addr_i  = a;
    req_wdata_i = d;
    req_strb_i  = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          idx;
    int          nrsp;
    int          nset;
    int          wcnt;
    logic        acc;
    logic        saw_full;
    logic [31:0] seen_addr [4];

    rst_i = 1'b1;
    rsp_ready_i = 1'b1;
    pready_i = 1'b0;
    prdata_i = '0;
    pslverr_i = 1'b0;
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk("rst_psel", psel_o === 1'b0);
    chk("rst_penable", penable_o === 1'b0);
    chk("rst_ready", req_ready_o === 1'b1);
    chk("rst_rsp_valid", rsp_valid_o === 1'b0);
    chk("rst_busy", busy_o === 1'b0);
    chk("rst_paddr", paddr_o === 32'h0);
    chk("rst_pstrb", pstrb_o === 4'h0);
    rst_i = 1'b0;
    tick();

    // 1: zero-wait write, latency T1/T2/T3
    set_req(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    pready_i = 1'b1;
    tick();  // T0
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("w_t0_psel", psel_o === 1'b0);
    chk("w_t0_busy", busy_o === 1'b1);
    tick();  // T1
    chk("w_t1_psel", psel_o === 1'b1);
    chk("w_t1_penable", penable_o === 1'b0);
    chk("w_t1_paddr", paddr_o === 32'h10);
    chk("w_t1_pwrite", pwrite_o === 1'b1);
    chk("w_t1_pwdata", pwdata_o === 32'hDEADBEEF);
    chk("w_t1_pstrb", pstrb_o === 4'hF);
    tick();  // T2
    chk("w_t2_penable", penable_o === 1'b1);
    chk("w_t2_rsp_valid", rsp_valid_o === 1'b0);
    tick();  // T3
    chk("w_t3_rsp_valid", rsp_valid_o === 1'b1);
    chk("w_t3_err", rsp_err_o === 2'b00);
    chk("w_t3_rdata", rsp_rdata_o === 32'h0);
    chk("w_t3_psel", psel_o === 1'b0);
    tick();
    chk("w_rsp_taken", rsp_valid_o === 1'b0);
    chk("w_idle_busy", busy_o === 1'b0);

    // 2: read with 3 wait cycles, strobes masked
    pready_i = 1'b0;
    set_req(1'b1, 1'b0, 32'h24, 32'h0, 4'hF);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    chk("r_setup_paddr", paddr_o === 32'h24);
    chk("r_setup_pwrite", pwrite_o === 1'b0);
    chk("r_setup_pstrb", pstrb_o === 4'h0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (penable_o) n++;
    end
    pready_i = 1'b1;
    prdata_i = 32'h12345678;
    tick();
    chk("r_penable_cycles", n === 4);
    chk("r_rsp_valid", rsp_valid_o === 1'b1);
    chk("r_rdata", rsp_rdata_o === 32'h12345678);
    chk("r_err", rsp_err_o === 2'b00);
    chk("r_penable_drop", penable_o === 1'b0);
    pready_i = 1'b0;
    prdata_i = 32'h0;
    tick();

    // 3: four back-to-back requests, slave with 2 wait states
    idx = 0;
    nrsp = 0;
    nset = 0;
    wcnt = 0;
    saw_full = 1'b0;
    set_req(1'b1, 1'b1, 32'h100, 32'hA0, 4'h3);
    for (int c = 0; c < 80 && !(idx == 4 && nrsp == 4); c++) begin
      acc = req_valid_i && req_ready_o;
      tick();
      if (acc) idx++;
      if (idx < 4) begin
        set_req(1'b1, 1'b1, 32'h100 + 32'(4 * idx), 32'hA0 + 32'(idx), 4'h3);
      end else begin
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
      if (!req_ready_o) saw_full = 1'b1;
      if (psel_o && !penable_o) begin
        if (nset < 4) seen_addr[nset] = paddr_o;
        nset++;
      end
      if (rsp_valid_o) begin
        nrsp++;
        chk("q_rsp_err", rsp_err_o === 2'b00);
      end
      if (penable_o) begin
        pready_i = (wcnt == 2);
        wcnt++;
      end else begin
        pready_i = 1'b0;
        wcnt = 0;
      end
    end
    chk("q_accepted", idx === 4);
    chk("q_responses", nrsp === 4);
    chk("q_setups", nset === 4);
    chk("q_saw_full", saw_full === 1'b1);
    chk("q_addr0", seen_addr[0] === 32'h100);
    chk("q_addr1", seen_addr[1] === 32'h104);
    chk("q_addr2", seen_addr[2] === 32'h108);
    chk("q_addr3", seen_addr[3] === 32'h10C);
    pready_i = 1'b0;
    tick();
    tick();
    chk("q_idle_busy", busy_o === 1'b0);

    // 4: slave error on read, then queued write completes cleanly
    set_req(1'b1, 1'b0, 32'h30, 32'h0, 4'hF);
    tick();
    set_req(1'b1, 1'b1, 32'h34, 32'h55, 4'h1);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    pready_i = 1'b1;
    pslverr_i = 1'b1;
    prdata_i = 32'hAAAA5555;
    tick();
    tick();
    chk("e_rsp_valid", rsp_valid_o === 1'b1);
    chk("e_err", rsp_err_o === 2'b01);
    chk("e_rdata", rsp_rdata_o === 32'h0);
    pslverr_i = 1'b0;
    tick();
    chk("e2_psel", psel_o === 1'b1);
    chk("e2_paddr", paddr_o === 32'h34);
    chk("e2_pstrb", pstrb_o === 4'h1);
    tick();
    tick();
    chk("e2_rsp_valid", rsp_valid_o === 1'b1);
    chk("e2_err", rsp_err_o === 2'b00);
    chk("e2_rdata", rsp_rdata_o === 32'h0);
    pready_i = 1'b0;
    prdata_i = 32'h0;
    tick();

    // 5a: timeout after exactly 8 ACCESS cycles
    set_req(1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (psel_o && penable_o) n++;
      else break;
    end
    chk("to_access_cycles", n === 8);
    chk("to_psel", psel_o === 1'b0);
    chk("to_rsp_valid", rsp_valid_o === 1'b1);
    chk("to_err", rsp_err_o === 2'b10);
    chk("to_rdata", rsp_rdata_o === 32'h0);
    tick();

    // 5b: pready rises in the 8th ACCESS cycle and beats the timeout
    set_req(1'b1, 1'b0, 32'h44, 32'h0, 4'h0);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (!psel_o) break;
      if (penable_o) begin
        n++;
        if (n == 8) begin
          pready_i = 1'b1;
          prdata_i = 32'h0BADF00D;
        end
      end
    end
    chk("tr_access_cycles", n === 8);
    chk("tr_rsp_valid", rsp_valid_o === 1'b1);
    chk("tr_err", rsp_err_o === 2'b00);
    chk("tr_rdata", rsp_rdata_o === 32'h0BADF00D);
    pready_i = 1'b0;
    prdata_i = 32'h0;
    tick();

    // 6: back-pressure on responses, then reset mid-ACCESS
    rsp_ready_i = 1'b0;
    pready_i = 1'b1;
    set_req(1'b1, 1'b1, 32'h50, 32'h1, 4'hF);
    tick();
    set_req(1'b1, 1'b1, 32'h54, 32'h2, 4'hF);
    tick();
    set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    chk("bp_rsp_valid", rsp_valid_o === 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_psel", psel_o === 1'b0);
    end
    chk("bp_hold_valid", rsp_valid_o === 1'b1);
    chk("bp_busy", busy_o === 1'b1);
    rsp_ready_i = 1'b1;
    tick();
    chk("bp_start_psel", psel_o === 1'b1);
    chk("bp_start_paddr", paddr_o === 32'h54);
    chk("bp_rsp_cleared", rsp_valid_o === 1'b0);
    rsp_ready_i = 1'b0;
    pready_i = 1'b0;
    tick();
    chk("rs_in_access", penable_o === 1'b1);
    rst_i = 1'b1;
    tick();
    chk("rs_psel", psel_o === 1'b0);
    chk("rs_penable", penable_o === 1'b0);
    chk("rs_rsp_valid", rsp_valid_o === 1'b0);
    chk("rs_ready", req_ready_o === 1'b1);
    chk("rs_busy", busy_o === 1'b0);
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    tick();
    tick();
    chk("rs_no_rsp", rsp_valid_o === 1'b0);
    chk("rs_stay_idle", psel_o === 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
